// File: rtl/vnu_pkg.sv
// Shared types and saturation helper for the VNU scheduler.
// Values are 11-bit two's complement, symmetric range +/-1023.
package vnu_pkg;

   localparam int W = 11;
   localparam int MAX_MAG = 1023;
   localparam int XW = 16;

   typedef logic signed [W-1:0] msg_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CALC,
      EMIT
   } vnu_state_t;

   // Clamp a wide signed value into the symmetric message range.
   function automatic msg_t sat11(input logic signed [XW-1:0] x);
      logic signed [XW-1:0] pmax;
      logic signed [XW-1:0] nmax;
      pmax = XW'(MAX_MAG);
      nmax = -XW'(MAX_MAG);
      if (x > pmax) return W'(pmax);
      if (x < nmax) return W'(nmax);
      return W'(x);
   endfunction

endpackage

// File: rtl/vnu_sched_compl2sm.sv
// Two's complement to codebase sign-magnitude converter.
// Output is {s, d[9:0] ^ {10{s}}}.
module compl2sm
   import vnu_pkg::*;
(
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_d
);

   assign o_d = {i_d[W-1], i_d[W-2:0] ^ {(W-1){i_d[W-1]}}};

endmodule

// File: rtl/vnu_sched.sv
// Per-node VNU scheduler: capture LLR, accumulate DV C2V messages,
// take the hard decision and stream DV extrinsic V2C messages.
module vnu_sched
   import vnu_pkg::*;
#(
   parameter int DV = 3
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_start,
   input  logic [W-1:0]                   i_llr,
   input  logic                           i_c2v_valid,
   input  logic [W-1:0]                   i_c2v_data,
   output logic                           o_c2v_ready,
   output logic                           o_v2c_valid,
   output logic [W-1:0]                   o_v2c_data,
   output logic [((DV>1)?$clog2(DV):1)-1:0] o_v2c_idx,
   input  logic                           i_v2c_ready,
   output logic                           o_hard,
   output logic                           o_busy,
   output logic                           o_done
);

   localparam int CW = (DV > 1) ? $clog2(DV) : 1;
   localparam int AW = W + $clog2(DV + 1);
   localparam logic [CW-1:0] LAST = CW'(DV - 1);

   vnu_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] idx_q, idx_d;
   logic [CW-1:0] sel;
   logic signed [AW-1:0] acc_q, acc_d;
   msg_t total_q, total_d;
   msg_t base, cin, ext;
   logic [W-1:0] sm, data_q, data_d;
   logic done_q, done_d;
   msg_t mem_q [DV];

   assign cin = sat11(XW'($signed(i_c2v_data)));

   // Operand select: CALC forms edge 0 from the fresh total, EMIT
   // prefetches the edge after the one currently presented.
   always_comb begin
      sel  = '0;
      base = total_q;
      if (state_q == CALC) base = sat11(XW'(acc_q));
      if (state_q == EMIT && idx_q != LAST) sel = idx_q + CW'(1);
   end

   assign ext = sat11(XW'(base) - XW'(mem_q[sel]));

   compl2sm u_c2sm (
      .i_d (ext),
      .o_d (sm)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      total_d = total_q;
      data_d  = data_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d = LOAD;
               cnt_d   = '0;
               acc_d   = AW'(sat11(XW'($signed(i_llr))));
            end
         end
         LOAD: begin
            if (i_c2v_valid) begin
               acc_d = acc_q + AW'(cin);
               if (cnt_q == LAST) begin
                  state_d = CALC;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         CALC: begin
            total_d = base;
            data_d  = sm;
            idx_d   = '0;
            state_d = EMIT;
         end
         EMIT: begin
            if (i_v2c_ready) begin
               if (idx_q == LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d  = idx_q + CW'(1);
                  data_d = sm;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
         total_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         total_q <= total_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (state_q == LOAD && i_c2v_valid) mem_q[cnt_q] <= cin;
   end

   assign o_c2v_ready = (state_q == LOAD);
   assign o_v2c_valid = (state_q == EMIT);
   assign o_busy      = (state_q != IDLE);
   assign o_v2c_data  = data_q;
   assign o_v2c_idx   = idx_q;
   assign o_hard      = total_q[W-1];
   assign o_done      = done_q;

endmodule

// File: tb/tb_vnu_sched.sv
// Randomized bench for vnu_sched with an arithmetic reference model
// and directed literal cases pinning the model.
module tb_vnu_sched;

   localparam int DV = 3;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b1;
   logic        i_start = 1'b0;
   logic [10:0] i_llr = '0;
   logic        i_c2v_valid = 1'b0;
   logic [10:0] i_c2v_data = '0;
   logic        i_v2c_ready = 1'b1;
   logic        o_c2v_ready, o_v2c_valid, o_hard, o_busy, o_done;
   logic [10:0] o_v2c_data;
   logic [1:0]  o_v2c_idx;

   int nvec = 0;
   int nerr = 0;
   int cyc = 0;

   typedef struct {
      logic [10:0] d;
      int          idx;
   } v2c_t;

   v2c_t        exp_q[$];
   logic [10:0] obs_q[$];
   bit          exp_hard = 1'b0;
   bit          done_nxt = 1'b0;
   int          fv_cyc = -1;
   int          rdy_mode = 0;
   int          bp_cnt = 0;

   vnu_sched #(.DV(DV)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_llr       (i_llr),
      .i_c2v_valid (i_c2v_valid),
      .i_c2v_data  (i_c2v_data),
      .o_c2v_ready (o_c2v_ready),
      .o_v2c_valid (o_v2c_valid),
      .o_v2c_data  (o_v2c_data),
      .o_v2c_idx   (o_v2c_idx),
      .i_v2c_ready (i_v2c_ready),
      .o_hard      (o_hard),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic int sat(input int x);
      if (x > 1023) return 1023;
      if (x < -1023) return -1023;
      return x;
   endfunction

   function automatic int sx(input logic [10:0] v);
      return sat(int'($signed(v)));
   endfunction

   function automatic logic [10:0] to_sm(input int e);
      if (e >= 0) return 11'(e);
      return {1'b1, 10'(-e - 1)};
   endfunction

   function automatic logic [10:0] obs_at(input int i);
      if (obs_q.size() > i) return obs_q[i];
      return 'x;
   endfunction

   function automatic logic [10:0] rnd11();
      if ($urandom_range(0, 7) == 0) return 11'h400;
      return 11'($urandom);
   endfunction

   // Compare process: every cycle outside reset.
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         done_nxt = 1'b0;
      end else begin
         chk("done", o_done, done_nxt);
         if (o_done) chk("busy_at_done", o_busy, 0);
         done_nxt = 1'b0;
         if (o_c2v_ready) chk("ready_excl", o_v2c_valid, 0);
         if (o_v2c_valid) begin
            if (fv_cyc < 0) fv_cyc = cyc;
            if (exp_q.size() == 0) begin
               chk("extra_v2c", 1, 0);
            end else begin
               chk("v2c_data", o_v2c_data, exp_q[0].d);
               chk("v2c_idx", o_v2c_idx, exp_q[0].idx);
               chk("hard", o_hard, exp_hard);
               if (i_v2c_ready) begin
                  obs_q.push_back(o_v2c_data);
                  done_nxt = (exp_q[0].idx == DV - 1);
                  exp_q.delete(0);
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         case (rdy_mode)
            0: i_v2c_ready = 1'b1;
            1: i_v2c_ready = ($urandom_range(0, 3) != 0);
            default: begin
               if (o_v2c_valid && o_v2c_idx == 2'd1 && bp_cnt < 4) begin
                  i_v2c_ready = 1'b0;
                  bp_cnt++;
               end else begin
                  i_v2c_ready = 1'b1;
               end
            end
         endcase
      end
   end

   task automatic run_job(input logic [10:0] llr, input logic [10:0] c0,
                          input logic [10:0] c1, input logic [10:0] c2,
                          input int gmode, input bit mid,
                          output int lat, output int fv);
      logic [10:0] c[3];
      int cv[3];
      int t, t0, n, g;
      bit ok;
      c = '{c0, c1, c2};
      n = 0;
      while (o_busy && n < 100) begin
         @(posedge i_clk);
         #1;
         n++;
      end
      chk("idle_wait", o_busy, 0);
      t = sx(llr);
      for (int i = 0; i < DV; i++) begin
         cv[i] = sx(c[i]);
         t += cv[i];
      end
      t = sat(t);
      exp_hard = (t < 0);
      for (int i = 0; i < DV; i++)
         exp_q.push_back('{to_sm(sat(t - cv[i])), i});
      obs_q.delete();
      fv_cyc = -1;
      i_llr = llr;
      i_start = 1'b1;
      i_c2v_valid = 1'b0;
      t0 = cyc;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      for (int k = 0; k < DV; k++) begin
         g = (gmode == 1) ? $urandom_range(0, 2) :
             (gmode == 2 && k == 1) ? 2 : 0;
         i_c2v_valid = 1'b0;
         repeat (g) begin
            @(posedge i_clk);
            #1;
         end
         i_c2v_valid = 1'b1;
         i_c2v_data = c[k];
         if (mid && k == 1) begin
            i_start = 1'b1;
            i_llr = 11'($urandom);
         end
         ok = 1'b0;
         for (int w = 0; w < 50 && !ok; w++) begin
            @(negedge i_clk);
            ok = o_c2v_ready;
            @(posedge i_clk);
            #1;
            i_start = 1'b0;
         end
         if (!ok) chk("c2v_timeout", 0, 1);
      end
      i_c2v_valid = 1'b0;
      i_c2v_data = 11'h3FF;
      ok = 1'b0;
      for (int w = 0; w < 200 && !ok; w++) begin
         @(negedge i_clk);
         ok = o_done;
      end
      chk("done_timeout", ok, 1);
      chk("queue_drained", exp_q.size(), 0);
      lat = cyc - t0;
      fv = fv_cyc - t0;
   endtask

   initial begin
      int lat, fv;
      #1 i_rst_n = 1'b0;
      #2;
      chk("rst_c2v_ready", o_c2v_ready, 0);
      chk("rst_v2c_valid", o_v2c_valid, 0);
      chk("rst_v2c_data", o_v2c_data, 0);
      chk("rst_v2c_idx", o_v2c_idx, 0);
      chk("rst_hard", o_hard, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      repeat (2) @(posedge i_clk);
      #1 i_rst_n = 1'b1;

      run_job(11'd10, 11'd5, 11'h7FD, 11'd7, 0, 1'b0, lat, fv);
      chk("j1_v0", obs_at(0), 11'h00E);
      chk("j1_v1", obs_at(1), 11'h016);
      chk("j1_v2", obs_at(2), 11'h00C);
      chk("j1_hard", o_hard, 0);
      chk("j1_done_cycle", lat, 8);
      chk("j1_first_v2c", fv, 5);

      run_job(11'h7EC, 11'h7FB, 11'h7FB, 11'd2, 0, 1'b0, lat, fv);
      chk("j2_v0", obs_at(0), 11'h416);
      chk("j2_v1", obs_at(1), 11'h416);
      chk("j2_v2", obs_at(2), 11'h41D);
      chk("j2_hard", o_hard, 1);

      // Abort a job after two C2V transfers.
      @(posedge i_clk);
      #1;
      i_llr = 11'd33;
      i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_c2v_valid = 1'b1;
      i_c2v_data = 11'd9;
      repeat (2) begin
         @(posedge i_clk);
         #1;
      end
      chk("pre_rst_busy", o_busy, 1);
      i_rst_n = 1'b0;
      #1;
      chk("arst_c2v_ready", o_c2v_ready, 0);
      chk("arst_busy", o_busy, 0);
      chk("arst_hard", o_hard, 0);
      chk("arst_outs", {o_v2c_valid, o_v2c_data, o_v2c_idx, o_done}, 0);
      i_c2v_valid = 1'b0;
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      run_job(11'd10, 11'd5, 11'h7FD, 11'd7, 0, 1'b0, lat, fv);
      chk("post_rst_v1", obs_at(1), 11'h016);
      chk("post_rst_lat", lat, 8);

      run_job(11'd1000, 11'h1F4, 11'h1F4, 11'h1F4, 0, 1'b0, lat, fv);
      for (int i = 0; i < DV; i++) chk("sat_pos", obs_at(i), 11'h20B);
      run_job(11'h400, 11'd0, 11'd0, 11'd0, 0, 1'b0, lat, fv);
      for (int i = 0; i < DV; i++) chk("sat_neg", obs_at(i), 11'h7FE);

      rdy_mode = 2;
      bp_cnt = 0;
      run_job(11'd50, 11'h7F0, 11'd3, 11'd100, 0, 1'b0, lat, fv);
      chk("bp_lat", lat, 12);
      chk("bp_count", obs_q.size(), 3);
      rdy_mode = 0;

      // C2V offered while idle must not be consumed.
      @(posedge i_clk);
      #1;
      i_c2v_valid = 1'b1;
      i_c2v_data = 11'h3FF;
      repeat (3) begin
         @(negedge i_clk);
         chk("idle_no_ready", o_c2v_ready, 0);
         @(posedge i_clk);
         #1;
      end
      run_job(11'h7F6, 11'd40, 11'h7D8, 11'd1, 2, 1'b1, lat, fv);
      chk("gap_first_v2c", fv, 7);
      chk("gap_lat", lat, 10);

      rdy_mode = 1;
      for (int j = 0; j < 40; j++)
         run_job(rnd11(), rnd11(), rnd11(), rnd11(), 1,
                 1'($urandom_range(0, 1)), lat, fv);
      rdy_mode = 0;
      repeat (3) @(posedge i_clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
